opicorv32_alu_arb: RTL and testbench
====================================

# opicorv32_alu_arb

Shares the single combinational `opicorv32_alu` instance between two requesters: port 0 (core execute path) and port 1 (PCPI/co-processor). The block runs round-robin arbitration, registers the winner's operands, and drives the ALU's one-hot `instr`/`is` decode inputs from a compact 4-bit op code. It captures `alu_out`/`alu_out_0` and returns the result to the granted requester over a valid/ready response handshake. It sits between the issue logic and the ALU, replacing the direct decode wiring.

## Interface
- No parameters. Data width is fixed at 32; there are 2 requesters.
- `clk` in 1: the single clock; everything is on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted (grant), one bit per requester.
- `req_op0`, `req_op1` in 4 each: ALU op code for each requester (`alu_op_t`).
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands (a→`reg_op1`, b→`reg_op2`).
- `rsp_valid[1:0]` out 2: response valid for each requester.
- `rsp_ready[1:0]` in 2: response accepted by each requester.
- `rsp_data` out 32: registered `alu_out`.
- `rsp_cmp` out 1: registered `alu_out_0`.
- `alu_reg_op1`, `alu_reg_op2` out 32 each: drive the ALU operands.
- `alu_instr` out 48: drives ALU `instr`.
- `alu_is` out 15: drives ALU `is`.
- `alu_out` in 32, `alu_out_0` in 1: ALU results.

## Operation
- Op codes: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLT=5, SLTU=6, BEQ=7, BNE=8, BLT=9, BGE=10, BLTU=11, BGEU=12. Codes 13–15 are reserved.
- Decode (all bits not listed are 0):
  - ADD: `is[6]`.
  - SUB: `instr[28]`.
  - XOR: `instr[32]`.
  - OR: `instr[35]`.
  - AND: all zero.
  - Every compare sets `is[13]`, plus:
    - SLT, BLT: `is[7]`.
    - SLTU, BLTU: nothing further.
    - BEQ: `instr[4]`.
    - BNE: `instr[5]`.
    - BGE: `instr[7]`.
    - BGEU: `instr[9]`.
  - Reserved codes decode to all zero, so the ALU performs AND. No error is flagged.
- FSM states:
  - IDLE: `req_ready[g]` = 1 only for grant `g` and only when `req_valid[g]` = 1. On the handshake, load `alu_reg_op*`, `alu_instr`, `alu_is`, record `g`, set `last = g`, and go to EXEC.
  - EXEC: one cycle. The ALU evaluates. At the edge, latch `rsp_data`/`rsp_cmp` and go to RESP.
  - RESP: `rsp_valid[g]` = 1. Hold `rsp_data`/`rsp_cmp` stable until `rsp_ready[g]`, then go to IDLE. `rsp_ready` of the non-granted port is ignored.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the winner is `~last`.
  - `last` resets to 1, so port 0 wins the first tie.
- `req_ready` is 0 in EXEC and RESP. A requester must hold `req_valid` and its operands stable until `req_ready`.
- ALU drive registers keep their values after an operation; they are not cleared.
- Reset, including in the middle of an operation:
  - State goes to IDLE; any pending result is discarded.
  - `rsp_valid` = 0, `req_ready` = 0, `rsp_data` = 0, `rsp_cmp` = 0.
  - All `alu_*` outputs = 0.
  - `last` = 1.

## Timing
- Handshake in cycle N → EXEC in N+1 → `rsp_valid` high in N+2.
- When `rsp_ready` is already high in N+2, the next grant can happen in N+3. Peak throughput is one operation per 3 cycles.
- `req_ready` is combinational from `req_valid` and state. No other output has a combinational path from an input.
- The `alu_out` → `rsp_data` capture allows exactly one full cycle for the ALU path.

## Structure
- Package `opicorv32_alu_pkg` holds:
  - the `alu_op_t` enum;
  - the FSM state enum;
  - localparams for the `instr`/`is` bit indices (4, 5, 7, 9, 28, 32, 35; 6, 7, 13).
- Sub-module `opicorv32_alu_opdec` is purely combinational: op → {`instr[47:0]`, `is[14:0]`}. It is instantiated once, on the muxed winner op, before the drive registers.
- Top level contains the arbiter, the FSM, and the registers.

## Test plan
- Port 0 ADD a=5, b=7 → `alu_instr`=0, `alu_is`=0x0040 in EXEC. `rsp_valid[0]` 2 cycles after the handshake, `rsp_data`=12.
- Port 1 SUB a=3, b=5 → `rsp_data`=0xFFFFFFFE. Port 1 BLT a=0xFFFFFFFF, b=1 → `rsp_cmp`=1, `rsp_data`=1. BLTU with the same operands → `rsp_cmp`=0.
- Both ports hold `req_valid` for 4 operations → grants 0, 1, 0, 1. Each `rsp_valid` appears only on the granted port.
- `rsp_ready` low for 3 cycles in RESP → `rsp_valid` and `rsp_data` are held unchanged. `req_ready` stays 0 until the response is accepted.
- `resetn` low during EXEC → the next cycle all outputs are 0, no `rsp_valid` ever appears, and after reset a tie is granted to port 0.
- Reserved op 14 with a=0xF0F0F0F0, b=0xFF00FF00 → `rsp_data`=0xF000F000 (AND).

Source files
------------

// File: rtl/opicorv32_alu_pkg.sv
// Shared types and decode bit positions for the ALU arbiter and op decoder.
package opicorv32_alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 48;
    localparam int unsigned IS_W    = 15;

    // Compact ALU operation codes presented by the requesters.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_BLT  = 4'd9,
        OP_BGE  = 4'd10,
        OP_BLTU = 4'd11,
        OP_BGEU = 4'd12
    } alu_op_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Bit positions inside the ALU one-hot instr vector.
    localparam int unsigned INSTR_BEQ_BIT  = 4;
    localparam int unsigned INSTR_BNE_BIT  = 5;
    localparam int unsigned INSTR_BGE_BIT  = 7;
    localparam int unsigned INSTR_BGEU_BIT = 9;
    localparam int unsigned INSTR_SUB_BIT  = 28;
    localparam int unsigned INSTR_XOR_BIT  = 32;
    localparam int unsigned INSTR_OR_BIT   = 35;

    // Bit positions inside the ALU is vector.
    localparam int unsigned IS_ADD_BIT = 6;
    localparam int unsigned IS_SLT_BIT = 7;
    localparam int unsigned IS_CMP_BIT = 13;

endpackage

// File: rtl/opicorv32_alu_opdec.sv
// Combinational translation of the compact op code into the ALU's
// one-hot instr/is decode vectors. Reserved codes decode to all zero,
// which the ALU executes as AND.
module opicorv32_alu_opdec
    import opicorv32_alu_pkg::*;
(
    input  alu_op_t              op,
    output logic [INSTR_W-1:0]   instr,
    output logic [IS_W-1:0]      is_bits
);

    // Op code to one-hot decode; every compare also raises the compare flag.
    always_comb begin
        instr   = 48'h0;
        is_bits = 15'h0;
        case (op)
            OP_ADD:  is_bits[IS_ADD_BIT] = 1'b1;
            OP_SUB:  instr[INSTR_SUB_BIT] = 1'b1;
            OP_XOR:  instr[INSTR_XOR_BIT] = 1'b1;
            OP_OR:   instr[INSTR_OR_BIT]  = 1'b1;
            OP_AND:  is_bits = 15'h0;
            OP_SLT, OP_BLT: begin
                is_bits[IS_CMP_BIT] = 1'b1;
                is_bits[IS_SLT_BIT] = 1'b1;
            end
            OP_SLTU, OP_BLTU: is_bits[IS_CMP_BIT] = 1'b1;
            OP_BEQ: begin
                is_bits[IS_CMP_BIT]  = 1'b1;
                instr[INSTR_BEQ_BIT] = 1'b1;
            end
            OP_BNE: begin
                is_bits[IS_CMP_BIT]  = 1'b1;
                instr[INSTR_BNE_BIT] = 1'b1;
            end
            OP_BGE: begin
                is_bits[IS_CMP_BIT]  = 1'b1;
                instr[INSTR_BGE_BIT] = 1'b1;
            end
            OP_BGEU: begin
                is_bits[IS_CMP_BIT]   = 1'b1;
                instr[INSTR_BGEU_BIT] = 1'b1;
            end
            default: begin
                instr   = 48'h0;
                is_bits = 15'h0;
            end
        endcase
    end

endmodule

// File: rtl/opicorv32_alu_arb.sv
// Round-robin sharing of one combinational ALU between the core execute
// path (port 0) and the co-processor path (port 1). A request is accepted
// in IDLE, the ALU evaluates for one full cycle in EXEC, and the result is
// held in RESP until the granted requester takes it.
module opicorv32_alu_arb
    import opicorv32_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op0,
    input  logic [3:0]           req_op1,
    input  logic [XLEN-1:0]      req_a0,
    input  logic [XLEN-1:0]      req_b0,
    input  logic [XLEN-1:0]      req_a1,
    input  logic [XLEN-1:0]      req_b1,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_cmp,
    output logic [XLEN-1:0]      alu_reg_op1,
    output logic [XLEN-1:0]      alu_reg_op2,
    output logic [INSTR_W-1:0]   alu_instr,
    output logic [IS_W-1:0]      alu_is,
    input  logic [XLEN-1:0]      alu_out,
    input  logic                 alu_out_0
);

    arb_state_t           state_r;
    arb_state_t           state_nxt_s;
    logic                 last_r;
    logic                 gnt_r;
    logic                 win_s;
    logic                 load_s;
    logic                 rsp_done_s;
    logic [1:0]           rsp_valid_r;
    alu_op_t              win_op_s;
    logic [XLEN-1:0]      win_a_s;
    logic [XLEN-1:0]      win_b_s;
    logic [INSTR_W-1:0]   dec_instr_s;
    logic [IS_W-1:0]      dec_is_s;

    // Winner selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        win_s = 1'b0;
        case (req_valid)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
    end

    assign win_op_s = win_s ? alu_op_t'(req_op1) : alu_op_t'(req_op0);
    assign win_a_s  = win_s ? req_a1 : req_a0;
    assign win_b_s  = win_s ? req_b1 : req_b0;

    opicorv32_alu_opdec u_opdec (
        .op      (win_op_s),
        .instr   (dec_instr_s),
        .is_bits (dec_is_s)
    );

    // Next-state and request handshake; req_ready is held low while in reset.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = 2'b00;
        load_s      = 1'b0;
        rsp_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (resetn && (req_valid != 2'b00)) begin
                    load_s      = 1'b1;
                    req_ready   = win_s ? 2'b10 : 2'b01;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready[gnt_r]) begin
                    rsp_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/decode drive, grant bookkeeping and response capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_r      <= 1'b1;
            gnt_r       <= 1'b0;
            alu_reg_op1 <= 32'h0;
            alu_reg_op2 <= 32'h0;
            alu_instr   <= 48'h0;
            alu_is      <= 15'h0;
            rsp_data    <= 32'h0;
            rsp_cmp     <= 1'b0;
            rsp_valid_r <= 2'b00;
        end else begin
            if (load_s) begin
                last_r      <= win_s;
                gnt_r       <= win_s;
                alu_reg_op1 <= win_a_s;
                alu_reg_op2 <= win_b_s;
                alu_instr   <= dec_instr_s;
                alu_is      <= dec_is_s;
            end
            if (state_r == ST_EXEC) begin
                rsp_data    <= alu_out;
                rsp_cmp     <= alu_out_0;
                rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 2'b00;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;

endmodule

// File: tb/tb_opicorv32_alu_arb.sv
// Self-checking bench for opicorv32_alu_arb with a behavioural ALU stand-in.
module tb_opicorv32_alu_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [31:0] rsp_data, alu_reg_op1, alu_reg_op2, alu_out;
    logic        rsp_cmp, alu_out_0;
    logic [47:0] alu_instr;
    logic [14:0] alu_is;

    int n_tests = 0;
    int n_fail  = 0;
    logic model_last;

    always #5 clk = ~clk;

    opicorv32_alu_arb dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cmp(rsp_cmp),
        .alu_reg_op1(alu_reg_op1), .alu_reg_op2(alu_reg_op2),
        .alu_instr(alu_instr), .alu_is(alu_is),
        .alu_out(alu_out), .alu_out_0(alu_out_0)
    );

    // ALU stand-in driven purely by the one-hot decode bits.
    logic eq_m, lts_m, ltu_m, cmp_m;
    always_comb begin
        eq_m  = (alu_reg_op1 == alu_reg_op2);
        lts_m = ($signed(alu_reg_op1) < $signed(alu_reg_op2));
        ltu_m = (alu_reg_op1 < alu_reg_op2);
        if (alu_instr[4])      cmp_m = eq_m;
        else if (alu_instr[5]) cmp_m = !eq_m;
        else if (alu_instr[7]) cmp_m = !lts_m;
        else if (alu_instr[9]) cmp_m = !ltu_m;
        else if (alu_is[7])    cmp_m = lts_m;
        else                   cmp_m = ltu_m;
        alu_out_0 = cmp_m;
        if (alu_is[13])         alu_out = {31'd0, cmp_m};
        else if (alu_is[6])     alu_out = alu_reg_op1 + alu_reg_op2;
        else if (alu_instr[28]) alu_out = alu_reg_op1 - alu_reg_op2;
        else if (alu_instr[32]) alu_out = alu_reg_op1 ^ alu_reg_op2;
        else if (alu_instr[35]) alu_out = alu_reg_op1 | alu_reg_op2;
        else                    alu_out = alu_reg_op1 & alu_reg_op2;
    end

    // Reference: comparison result of an op code, straight from the op semantics.
    function automatic logic ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd5, 4'd9:   return $signed(a) < $signed(b);
            4'd7:         return a == b;
            4'd8:         return a != b;
            4'd10:        return !($signed(a) < $signed(b));
            4'd12:        return !(a < b);
            default:      return a < b;
        endcase
    endfunction

    // Reference: data result of an op code.
    function automatic logic [31:0] ref_data(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a ^ b;
            4'd3:  return a | b;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                   return {31'd0, ref_cmp(op, a, b)};
            default: return a & b;
        endcase
    endfunction

    function automatic logic [1:0] oh(input int p);
        return (p != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        set_req(0, 4'd0, $urandom, $urandom);
        set_req(1, 4'd1, $urandom, $urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_hs req_ready=%b rsp_valid=%b expected 00/00", req_ready, rsp_valid);
        end
        n_tests++;
        if (rsp_data !== 32'h0 || rsp_cmp !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp data=%h cmp=%b expected 0/0", rsp_data, rsp_cmp);
        end
        n_tests++;
        if (alu_reg_op1 !== 32'h0 || alu_reg_op2 !== 32'h0 || alu_instr !== 48'h0 || alu_is !== 15'h0) begin
            n_fail++; $display("FAIL reset_alu op1=%h op2=%h instr=%h is=%h expected all 0", alu_reg_op1, alu_reg_op2, alu_instr, alu_is);
        end
        @(posedge clk); #1;
        resetn = 1'b1; req_valid = 2'b00;
        model_last = 1'b1;
    endtask

    task automatic test_add_timing;
        @(posedge clk); #1;
        rsp_ready = 2'b00; set_req(0, 4'd0, 32'd5, 32'd7); req_valid = 2'b01;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant req_ready=%b expected 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (alu_instr !== 48'h0 || alu_is !== 15'h0040) begin
            n_fail++; $display("FAIL add_decode instr=%h is=%h expected 0/0040", alu_instr, alu_is);
        end
        n_tests++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL add_exec rsp_valid=%b req_ready=%b expected 00/00", rsp_valid, req_ready);
        end
        @(posedge clk); #1; rsp_ready = 2'b01;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd12) begin
            n_fail++; $display("FAIL add_resp rsp_valid=%b data=%h expected 01/0000000c", rsp_valid, rsp_data);
        end
        @(posedge clk); #1; rsp_ready = 2'b00;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_done rsp_valid=%b expected 00", rsp_valid); end
        model_last = 1'b0;
    endtask

    task automatic test_directed;
        int          d_port [6] = '{1, 1, 1, 0, 0, 1};
        logic [3:0]  d_op   [6] = '{4'd1, 4'd9, 4'd11, 4'd14, 4'd7, 4'd10};
        logic [31:0] d_a    [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h1234ABCD, 32'hFFFFFFFF};
        logic [31:0] d_b    [6] = '{32'd5, 32'd1, 32'd1, 32'hFF00FF00, 32'h1234ABCD, 32'd1};
        logic [31:0] d_data [6] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000F000, 32'd1, 32'd0};
        logic        d_cmp  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        d_chk  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_req(d_port[i], d_op[i], d_a[i], d_b[i]);
            req_valid = oh(d_port[i]); rsp_ready = oh(d_port[i]);
            @(negedge clk);
            n_tests++;
            if (req_ready !== oh(d_port[i])) begin
                n_fail++; $display("FAIL dir%0d_grant req_ready=%b expected %b", i, req_ready, oh(d_port[i]));
            end
            @(posedge clk); #1; req_valid = 2'b00;
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== oh(d_port[i]) || rsp_data !== d_data[i]) begin
                n_fail++; $display("FAIL dir%0d_resp rsp_valid=%b data=%h expected %b/%h", i, rsp_valid, rsp_data, oh(d_port[i]), d_data[i]);
            end
            if (d_chk[i]) begin
                n_tests++;
                if (rsp_cmp !== d_cmp[i]) begin
                    n_fail++; $display("FAIL dir%0d_cmp got=%b expected %b", i, rsp_cmp, d_cmp[i]);
                end
            end
            model_last = (d_port[i] != 0);
        end
        @(posedge clk); #1; rsp_ready = 2'b00;
    endtask

    task automatic test_back_to_back;
        logic [3:0]  c_op [2];
        logic [31:0] c_a  [2];
        logic [31:0] c_b  [2];
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        int          w;
        @(posedge clk); #1; resetn = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1; resetn = 1'b1; model_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            c_op[p] = 4'($urandom_range(0, 12)); c_a[p] = $urandom; c_b[p] = $urandom;
            set_req(p, c_op[p], c_a[p], c_b[p]);
        end
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            @(negedge clk);
            n_tests++;
            if (req_ready !== oh(w)) begin n_fail++; $display("FAIL rr%0d_grant req_ready=%b expected %b", k, req_ready, oh(w)); end
            e_op = c_op[w]; e_a = c_a[w]; e_b = c_b[w];
            c_op[w] = 4'($urandom_range(0, 12)); c_a[w] = $urandom; c_b[w] = $urandom;
            @(posedge clk); #1; set_req(w, c_op[w], c_a[w], c_b[w]);
            @(negedge clk);
            n_tests++;
            if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr%0d_exec req_ready=%b expected 00", k, req_ready); end
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== oh(w) || rsp_data !== ref_data(e_op, e_a, e_b) || rsp_cmp !== ref_cmp(e_op, e_a, e_b)) begin
                n_fail++; $display("FAIL rr%0d_resp rsp_valid=%b data=%h cmp=%b expected %b/%h/%b", k, rsp_valid, rsp_data, rsp_cmp,
                                   oh(w), ref_data(e_op, e_a, e_b), ref_cmp(e_op, e_a, e_b));
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00; rsp_ready = 2'b00; model_last = 1'b1;
    endtask

    task automatic test_backpressure;
        logic [3:0]  op;
        logic [31:0] a, b, e_data;
        op = 4'($urandom_range(0, 12)); a = $urandom; b = $urandom;
        e_data = ref_data(op, a, b);
        @(posedge clk); #1; set_req(0, op, a, b); req_valid = 2'b01; rsp_ready = 2'b00;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant req_ready=%b expected 01", req_ready); end
        @(posedge clk); #1; set_req(1, 4'd2, 32'h0F0F0F0F, 32'h00FF00FF); req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1; rsp_ready = 2'b10;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 2'b01 || rsp_data !== e_data || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL bp_hold%0d rsp_valid=%b data=%h req_ready=%b expected 01/%h/00", c, rsp_valid, rsp_data, req_ready, e_data);
            end
        end
        @(posedge clk); #1; rsp_ready = 2'b01;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== e_data) begin
            n_fail++; $display("FAIL bp_accept rsp_valid=%b data=%h expected 01/%h", rsp_valid, rsp_data, e_data);
        end
        @(posedge clk); #1; rsp_ready = 2'b00;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL bp_next req_ready=%b rsp_valid=%b expected 10/00", req_ready, rsp_valid);
        end
        @(posedge clk); #1; req_valid = 2'b00; rsp_ready = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'h0FF00FF0) begin
            n_fail++; $display("FAIL bp_port1 rsp_valid=%b data=%h expected 10/0ff00ff0", rsp_valid, rsp_data);
        end
        @(posedge clk); #1; rsp_ready = 2'b00; model_last = 1'b1;
    endtask

    task automatic test_reset_mid;
        int seen;
        @(posedge clk); #1; set_req(1, 4'd0, 32'h11111111, 32'h22222222); req_valid = 2'b10; rsp_ready = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rm_grant req_ready=%b expected 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1; model_last = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_data !== 32'h0 || rsp_cmp !== 1'b0 ||
            alu_reg_op1 !== 32'h0 || alu_reg_op2 !== 32'h0 || alu_instr !== 48'h0 || alu_is !== 15'h0) begin
            n_fail++; $display("FAIL rm_clear rsp_valid=%b data=%h cmp=%b op1=%h op2=%h instr=%h is=%h expected all 0",
                               rsp_valid, rsp_data, rsp_cmp, alu_reg_op1, alu_reg_op2, alu_instr, alu_is);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rsp_valid !== 2'b00) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rm_no_rsp cycles_with_rsp_valid=%0d expected 0", seen); end
        @(posedge clk); #1;
        set_req(0, 4'd3, 32'hA0A0A0A0, 32'h05050505); set_req(1, 4'd0, 32'd1, 32'd1); req_valid = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_tie req_ready=%b expected 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL rm_after rsp_valid=%b data=%h expected 01/a5a5a5a5", rsp_valid, rsp_data);
        end
        @(posedge clk); #1; rsp_ready = 2'b00; model_last = 1'b0;
    endtask

    task automatic test_random;
        logic [1:0]  mask;
        logic [3:0]  op [2];
        logic [31:0] a  [2];
        logic [31:0] b  [2];
        logic [31:0] e_data;
        logic        e_cmp;
        int          w, delay;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                op[p] = 4'($urandom_range(0, 15)); a[p] = $urandom;
                b[p] = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
            end
            w = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : (model_last ? 0 : 1);
            e_data = ref_data(op[w], a[w], b[w]);
            e_cmp  = ref_cmp(op[w], a[w], b[w]);
            @(posedge clk); #1;
            set_req(0, op[0], a[0], b[0]); set_req(1, op[1], a[1], b[1]);
            req_valid = mask; rsp_ready = 2'b00;
            @(negedge clk);
            n_tests++;
            if (req_ready !== oh(w)) begin n_fail++; $display("FAIL rnd%0d_grant req_ready=%b expected %b", it, req_ready, oh(w)); end
            model_last = (w != 0);
            @(posedge clk); #1; req_valid = 2'b00;
            delay = $urandom_range(0, 2);
            for (int d = 0; d <= delay; d++) begin
                @(posedge clk); #1;
                rsp_ready = ((d == delay) ? oh(w) : 2'b00) | (~oh(w) & 2'($urandom_range(0, 3)));
                @(negedge clk);
                n_tests++;
                if (rsp_valid !== oh(w) || rsp_data !== e_data || rsp_cmp !== e_cmp) begin
                    n_fail++; $display("FAIL rnd%0d_resp op=%0d rsp_valid=%b data=%h cmp=%b expected %b/%h/%b",
                                       it, op[w], rsp_valid, rsp_data, rsp_cmp, oh(w), e_data, e_cmp);
                end
            end
            @(posedge clk); #1; rsp_ready = 2'b00;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rnd%0d_done rsp_valid=%b expected 00", it, rsp_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = 2'b00; rsp_ready = 2'b00; resetn = 1'b0; model_last = 1'b1;
        set_req(0, 4'd0, 32'h0, 32'h0);
        set_req(1, 4'd0, 32'h0, 32'h0);
        test_reset();
        test_add_timing();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
